ex_stage_core: RTL and testbench

//  D/E pipeline register plus the E-stage ALU and the D-stage branch comparator of the 5-stage MIPS core.

---
 rtl/ex_stage_core.sv | 150 +++++++++++++++
 tb/tb_ex_stage_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_core.sv
// ex_stage_core: D/E pipeline register, E-stage ALU and D-stage branch comparator.
// The pipeline register holds on stall (en=1) and loads a nop bubble on clr.
// The ALU works on the registered operands, which E-stage forwarding can override.
// The branch comparator works directly on the D-side operands.
module ex_stage_core #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [DW-1:0] e32_d,
  input  logic [DW-1:0] pc_d,
  input  logic [DW-1:0] instr_d,
  input  logic [4:0]    a1_d,
  input  logic [4:0]    a2_d,
  input  logic [4:0]    a3_d,
  input  logic [OPW-1:0] alu_op_d,
  input  logic          alua_src_d,
  input  logic          alub_src_d,
  input  logic          reg_wr_d,
  input  logic [5:0]    br_sel_d,
  input  logic [DW-1:0] rd1_e_fwd,
  input  logic [DW-1:0] rd2_e_fwd,
  input  logic          fwd1_e,
  input  logic          fwd2_e,
  output logic          br_take,
  output logic [DW-1:0] rd1_e,
  output logic [DW-1:0] rd2_e,
  output logic [DW-1:0] e32_e,
  output logic [DW-1:0] pc_e,
  output logic [DW-1:0] instr_e,
  output logic [4:0]    a1_e,
  output logic [4:0]    a2_e,
  output logic [4:0]    a3_e,
  output logic          reg_wr_e,
  output logic [DW-1:0] ao_e
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_OR   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(7);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(8);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(9);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(10);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(11);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(12);

  logic [DW-1:0]  r_rd1, r_rd2, r_e32, r_pc, r_instr;
  logic [4:0]     r_a1, r_a2, r_a3;
  logic           r_reg_wr;
  logic [OPW-1:0] r_alu_op;
  logic           r_alua_src, r_alub_src;

  logic [DW-1:0]  w_a, w_b, w_ao;
  logic [4:0]     w_shamt;
  logic           w_eq, w_neg, w_zero;

  // D/E pipeline register: reset and clr both insert a bubble, en stalls.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_e32      <= '0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_a3       <= '0;
      r_reg_wr   <= 1'b0;
      r_alu_op   <= '0;
      r_alua_src <= 1'b0;
      r_alub_src <= 1'b0;
    end else if (!en) begin
      r_rd1      <= rd1_d;
      r_rd2      <= rd2_d;
      r_e32      <= e32_d;
      r_pc       <= pc_d;
      r_instr    <= instr_d;
      r_a1       <= a1_d;
      r_a2       <= a2_d;
      r_a3       <= a3_d;
      r_reg_wr   <= reg_wr_d;
      r_alu_op   <= alu_op_d;
      r_alua_src <= alua_src_d;
      r_alub_src <= alub_src_d;
    end
  end

  // Operand select: immediate has priority over forwarding, forwarding over the registered value.
  assign w_a     = r_alua_src ? r_e32 : (fwd1_e ? rd1_e_fwd : r_rd1);
  assign w_b     = r_alub_src ? r_e32 : (fwd2_e ? rd2_e_fwd : r_rd2);
  assign w_shamt = w_a[4:0];

  // ALU: arithmetic wraps silently; unknown opcodes produce zero.
  always_comb begin
    w_ao = '0;
    case (r_alu_op)
      OP_ADD:   w_ao = w_a + w_b;
      OP_SUB:   w_ao = w_a - w_b;
      OP_OR:    w_ao = w_a | w_b;
      OP_AND:   w_ao = w_a & w_b;
      OP_XOR:   w_ao = w_a ^ w_b;
      OP_NOR:   w_ao = ~(w_a | w_b);
      OP_SLT:   w_ao = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU:  w_ao = {{(DW-1){1'b0}}, (w_a < w_b)};
      OP_SLL:   w_ao = w_b << w_shamt;
      OP_SRL:   w_ao = w_b >> w_shamt;
      OP_SRA:   w_ao = $unsigned($signed(w_b) >>> w_shamt);
      OP_LUI:   w_ao = w_b << 16;
      OP_PASSB: w_ao = w_b;
      default:  w_ao = '0;
    endcase
  end

  // Branch comparator on D-side operands; multiple selects OR together.
  assign w_eq   = (rd1_d == rd2_d);
  assign w_neg  = rd1_d[DW-1];
  assign w_zero = (rd1_d == '0);

  always_comb begin
    br_take = 1'b0;
    if (br_sel_d[5] &&  w_eq)            br_take = 1'b1;
    if (br_sel_d[4] && !w_eq)            br_take = 1'b1;
    if (br_sel_d[3] && !w_neg)           br_take = 1'b1;
    if (br_sel_d[2] && !w_neg && !w_zero) br_take = 1'b1;
    if (br_sel_d[1] && (w_neg || w_zero)) br_take = 1'b1;
    if (br_sel_d[0] &&  w_neg)           br_take = 1'b1;
  end

  assign rd1_e    = r_rd1;
  assign rd2_e    = r_rd2;
  assign e32_e    = r_e32;
  assign pc_e     = r_pc;
  assign instr_e  = r_instr;
  assign a1_e     = r_a1;
  assign a2_e     = r_a2;
  assign a3_e     = r_a3;
  assign reg_wr_e = r_reg_wr;
  assign ao_e     = w_ao;

endmodule

// File: tb/tb_ex_stage_core.sv
// Directed testbench for ex_stage_core with hand-computed expected values.
module tb_ex_stage_core;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] rd1_d, rd2_d, e32_d, pc_d, instr_d;
  logic [4:0]  a1_d, a2_d, a3_d;
  logic [3:0]  alu_op_d;
  logic        alua_src_d, alub_src_d, reg_wr_d;
  logic [5:0]  br_sel_d;
  logic [31:0] rd1_e_fwd, rd2_e_fwd;
  logic        fwd1_e, fwd2_e;
  logic        br_take;
  logic [31:0] rd1_e, rd2_e, e32_e, pc_e, instr_e, ao_e;
  logic [4:0]  a1_e, a2_e, a3_e;
  logic        reg_wr_e;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage_core #(.DW(32), .OPW(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .e32_d(e32_d), .pc_d(pc_d), .instr_d(instr_d),
    .a1_d(a1_d), .a2_d(a2_d), .a3_d(a3_d), .alu_op_d(alu_op_d),
    .alua_src_d(alua_src_d), .alub_src_d(alub_src_d), .reg_wr_d(reg_wr_d),
    .br_sel_d(br_sel_d), .rd1_e_fwd(rd1_e_fwd), .rd2_e_fwd(rd2_e_fwd),
    .fwd1_e(fwd1_e), .fwd2_e(fwd2_e), .br_take(br_take),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .e32_e(e32_e), .pc_e(pc_e), .instr_e(instr_e),
    .a1_e(a1_e), .a2_e(a2_e), .a3_e(a3_e), .reg_wr_e(reg_wr_e), .ao_e(ao_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a D-stage ALU instruction and clock it into E.
  task automatic load_alu(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                          input logic [3:0] op, input logic asrc, input logic bsrc);
    rd1_d = r1; rd2_d = r2; e32_d = imm; alu_op_d = op;
    alua_src_d = asrc; alub_src_d = bsrc;
    tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    rd1_d = 32'h1111_1111; rd2_d = 32'h2222_2222; e32_d = 32'h3333_3333;
    pc_d = 32'h0000_0400; instr_d = 32'h0123_4567;
    a1_d = 5'd1; a2_d = 5'd2; a3_d = 5'd3; alu_op_d = 4'd0;
    alua_src_d = 1'b0; alub_src_d = 1'b0; reg_wr_d = 1'b1; br_sel_d = 6'b0;
    rd1_e_fwd = 32'h0; rd2_e_fwd = 32'h0; fwd1_e = 1'b0; fwd2_e = 1'b0;

    // Reset clears every registered field
    tick();
    check("rst_rd1", rd1_e, 32'h0);
    check("rst_pc", pc_e, 32'h0);
    check("rst_instr", instr_e, 32'h0);
    check("rst_a3", {27'h0, a3_e}, 32'h0);
    check("rst_regwr", {31'h0, reg_wr_e}, 32'h0);
    check("rst_ao", ao_e, 32'h0);
    reset = 1'b0;

    // Load with SUB, verify all fields came across in one cycle
    pc_d = 32'h0000_0100; instr_d = 32'hDEAD_BEEF; a1_d = 5'd4; a2_d = 5'd5; a3_d = 5'd7;
    load_alu(32'd5, 32'hFFFF_FFFF, 32'h0, 4'd1, 1'b0, 1'b0);
    check("sub", ao_e, 32'd6);
    check("load_pc", pc_e, 32'h0000_0100);
    check("load_instr", instr_e, 32'hDEAD_BEEF);
    check("load_a1", {27'h0, a1_e}, 32'd4);
    check("load_a2", {27'h0, a2_e}, 32'd5);
    check("load_a3", {27'h0, a3_e}, 32'd7);
    check("load_regwr", {31'h0, reg_wr_e}, 32'd1);
    check("load_rd2", rd2_e, 32'hFFFF_FFFF);
    load_alu(32'd5, 32'hFFFF_FFFF, 32'h0, 4'd6, 1'b0, 1'b0);
    check("slt", ao_e, 32'd0);
    load_alu(32'd5, 32'hFFFF_FFFF, 32'h0, 4'd7, 1'b0, 1'b0);
    check("sltu", ao_e, 32'd1);

    // Stall: new inputs must not enter the register
    en = 1'b1; pc_d = 32'h0000_0200;
    load_alu(32'd99, 32'd1, 32'h0, 4'd0, 1'b0, 1'b0);
    check("hold_rd1", rd1_e, 32'd5);
    check("hold_pc", pc_e, 32'h0000_0100);
    check("hold_ao", ao_e, 32'd1);

    // clr wins over en
    clr = 1'b1;
    tick();
    check("bubble_regwr", {31'h0, reg_wr_e}, 32'd0);
    check("bubble_instr", instr_e, 32'h0);
    check("bubble_a3", {27'h0, a3_e}, 32'h0);
    check("bubble_rd1", rd1_e, 32'h0);
    clr = 1'b0; en = 1'b0;

    // Immediate and shift operations
    load_alu(32'h0, 32'h0, 32'h0000_1234, 4'd11, 1'b0, 1'b1);
    check("lui", ao_e, 32'h1234_0000);
    load_alu(32'd4, 32'h8000_0000, 32'h0, 4'd10, 1'b0, 1'b0);
    check("sra", ao_e, 32'hF800_0000);
    load_alu(32'd4, 32'h8000_0000, 32'h0, 4'd9, 1'b0, 1'b0);
    check("srl", ao_e, 32'h0800_0000);
    load_alu(32'd36, 32'h0000_0003, 32'h0, 4'd8, 1'b0, 1'b0);
    check("sll_amt5", ao_e, 32'h0000_0030);
    load_alu(32'h0000_0008, 32'h0, 32'h0000_0010, 4'd8, 1'b1, 1'b0);
    check("sll_imm_a", ao_e, 32'h0);
    load_alu(32'hF0F0_0000, 32'h0000_0003, 32'h0, 4'd0, 1'b1, 1'b0);
    check("add_imm_a", ao_e, 32'h0000_0003);
    load_alu(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 4'd0, 1'b0, 1'b0);
    check("add_wrap", ao_e, 32'h0);
    load_alu(32'h0000_0000, 32'h0000_0001, 32'h0, 4'd1, 1'b0, 1'b0);
    check("sub_wrap", ao_e, 32'hFFFF_FFFF);
    load_alu(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 4'd2, 1'b0, 1'b0);
    check("or", ao_e, 32'hFFF0_FFF0);
    load_alu(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 4'd3, 1'b0, 1'b0);
    check("and", ao_e, 32'h00F0_00F0);
    load_alu(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 4'd4, 1'b0, 1'b0);
    check("xor", ao_e, 32'hFF00_FF00);
    load_alu(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 4'd5, 1'b0, 1'b0);
    check("nor", ao_e, 32'h000F_000F);
    load_alu(32'hFFFF_FFFF, 32'd1, 32'h0, 4'd6, 1'b0, 1'b0);
    check("slt_neg", ao_e, 32'd1);
    load_alu(32'h1, 32'hCAFE_F00D, 32'h0, 4'd12, 1'b0, 1'b0);
    check("passb", ao_e, 32'hCAFE_F00D);
    load_alu(32'h1, 32'hCAFE_F00D, 32'h0, 4'd13, 1'b0, 1'b0);
    check("op_undef", ao_e, 32'h0);

    // Forwarding overrides registered operands
    load_alu(32'd100, 32'd3, 32'h0, 4'd0, 1'b0, 1'b0);
    fwd1_e = 1'b1; rd1_e_fwd = 32'd7;
    #1;
    check("fwd1_add", ao_e, 32'd10);
    fwd2_e = 1'b1; rd2_e_fwd = 32'd20;
    #1;
    check("fwd2_add", ao_e, 32'd27);
    fwd1_e = 1'b0; fwd2_e = 1'b0;

    // Reset after a load clears again
    load_alu(32'd9, 32'd9, 32'h0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1; clr = 1'b0; en = 1'b1;
    tick();
    check("rst2_rd1", rd1_e, 32'h0);
    reset = 1'b0; en = 1'b0;

    // Branch comparator (combinational)
    rd1_d = 32'h0; rd2_d = 32'h5;
    br_sel_d = 6'b001000; #1; check("bgez_0", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b000100; #1; check("bgtz_0", {31'h0, br_take}, 32'd0);
    br_sel_d = 6'b000010; #1; check("blez_0", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b000001; #1; check("bltz_0", {31'h0, br_take}, 32'd0);
    rd1_d = 32'h8000_0000;
    br_sel_d = 6'b000001; #1; check("bltz_neg", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b001000; #1; check("bgez_neg", {31'h0, br_take}, 32'd0);
    rd1_d = 32'd1;
    br_sel_d = 6'b000100; #1; check("bgtz_pos", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b000010; #1; check("blez_pos", {31'h0, br_take}, 32'd0);
    rd1_d = 32'd3; rd2_d = 32'd3;
    br_sel_d = 6'b100000; #1; check("beq_eq", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b010000; #1; check("bne_eq", {31'h0, br_take}, 32'd0);
    rd2_d = 32'd4;
    br_sel_d = 6'b100000; #1; check("beq_ne", {31'h0, br_take}, 32'd0);
    br_sel_d = 6'b010000; #1; check("bne_ne", {31'h0, br_take}, 32'd1);
    br_sel_d = 6'b000000; #1; check("br_none", {31'h0, br_take}, 32'd0);
    rd1_d = 32'h0;
    br_sel_d = 6'b000101; #1; check("multi_off", {31'h0, br_take}, 32'd0);
    br_sel_d = 6'b100101; #1; check("multi_beq_ne", {31'h0, br_take}, 32'd0);
    br_sel_d = 6'b010101; #1; check("multi_bne", {31'h0, br_take}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
